lock_sequencer: RTL and testbench
=================================

# lock_sequencer

Sequences the door lock actuator: accepts single-cycle lock/unlock commands from the keypad/authentication logic, drives the `locked` level consumed by `servo_controller`, and enforces a servo travel (settle) window during which new commands are refused. Also provides auto-relock after a configurable idle time once the door is closed, plus busy/done/error status for the LED and display logic. Sits between the authentication FSM and `servo_controller`, in the 50 MHz `clk` domain.

## Interface
Parameters:
- `SETTLE_CYCLES`, 25_000_000: servo travel window in clocks (500 ms at 50 MHz); minimum 1.
- `RELOCK_CYCLES`, 250_000_000: idle time in UNLOCKED before auto-relock (5 s); minimum 1.
- `AUTO_RELOCK`, 1: 1 enables auto-relock, 0 disables it.

Ports:
- `clk` in 1: 50 MHz system clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `unlock_req` in 1: one-cycle unlock command.
- `lock_req` in 1: one-cycle lock command.
- `door_closed` in 1: door sensor, already synchronised and debounced; 1 means closed.
- `locked` out 1: level to `servo_controller`; 1 means lock position.
- `busy` out 1: high during a settle window.
- `done` out 1: one-cycle pulse when a settle window completes.
- `err` out 1: one-cycle pulse when a command is rejected.
- `state_o` out 2: current state encoding for the display.

## Operation
- States, encoded in `state_o`:
  - LOCKED = 0
  - UNLOCKING = 1
  - UNLOCKED = 2
  - LOCKING = 3
- LOCKED:
  - `unlock_req` alone → UNLOCKING; load the settle timer.
  - `lock_req` alone: no state change, no `err` (already locked).
- UNLOCKING:
  - The settle timer counts down.
  - On expiry → UNLOCKED; pulse `done`; load the relock timer.
  - Any request in this state → pulse `err`; the request is dropped.
- UNLOCKED:
  - `lock_req` with `door_closed`=1 → LOCKING; load the settle timer.
  - `lock_req` with `door_closed`=0 → pulse `err`; stay in UNLOCKED.
  - `unlock_req` → reload the relock timer (extends the open time); no `err`.
  - Relock timer (AUTO_RELOCK=1):
    - Counts only while `door_closed`=1.
    - Reloads on any cycle where `door_closed`=0.
    - On expiry → LOCKING.
- LOCKING:
  - The settle timer counts down; on expiry → LOCKED and pulse `done`.
  - Any request → pulse `err`.
  - If `door_closed` falls during LOCKING → UNLOCKING (abort) with a fresh settle load; pulse `err`.
- `lock_req` and `unlock_req` high in the same cycle, in any state → pulse `err`; both are ignored.
- `locked` is 1 in LOCKED and LOCKING, and 0 in UNLOCKING and UNLOCKED.
- Timers:
  - One shared down-counter, width $clog2(max(SETTLE_CYCLES, RELOCK_CYCLES)+1).
  - Load value N−1; expiry when the count is 0 while the state is active. The dwell is exactly N cycles.

## Timing
- Reset values: state LOCKED (fail-secure), `locked`=1, `busy`=0, `done`=0, `err`=0, `state_o`=0, timer=0.
- Reset asserted mid-settle forces LOCKED on the next edge regardless of state or `door_closed`.
- All outputs are registered.
- Request latency:
  - A request sampled at edge k updates `state_o`, `locked` and `busy` after edge k.
  - `err` for a rejected request is high for the cycle after edge k.
- Settle window: `busy` is high for exactly SETTLE_CYCLES cycles.
  - `done` is high in the first cycle after `busy` falls, coincident with the new `state_o`.
- Auto-relock: entering LOCKING occurs exactly RELOCK_CYCLES cycles after UNLOCKED entry, or after the last reload, with the door continuously closed.
- A request arriving on the same edge as timer expiry is rejected with `err` because the old state is still in effect; expiry still proceeds.
- The door-open abort has priority over settle expiry in the same cycle.

## Structure
- Package `lock_pkg`:
  - `lock_state_t` enum, 2-bit, with values as listed under Operation.
  - Default cycle constants for SETTLE and RELOCK.
- Sub-module `cycle_timer`:
  - Parameterised-width down-counter.
  - Ports: `clk`, `reset`, `load`, `load_val`, `en`, `expired`.
  - Instantiated once, shared by both phases.
- FSM and output registers live in `lock_sequencer`.

## Test plan
Use SETTLE_CYCLES=4, RELOCK_CYCLES=10 unless noted.
- Reset then idle 20 cycles → `locked`=1, `state_o`=0, no pulses.
- `unlock_req` at cycle 0 → `locked`=0 and `busy`=1 for cycles 1–4; `done` in cycle 5; `state_o`=2.
- In UNLOCKED with door closed and no requests → `state_o`=3 exactly 10 cycles after UNLOCKED entry; `locked`=1 and `done` 4 cycles later.
- In UNLOCKED, `door_closed`=0 for 30 cycles then 1:
  - No relock while open.
  - Relock 10 cycles after the door closes.
  - A `lock_req` while open → `err` 1 cycle, `state_o` stays 2.
- During LOCKING, drop `door_closed` → `err`, `state_o`=1, `locked`=0, then UNLOCKED after 4 cycles.
- Both requests asserted in LOCKED → `err`, `locked` stays 1.
- Assert `reset` mid-UNLOCKING → LOCKED on the next edge, `busy`=0.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types and defaults for the door lock sequencer.
// Provides the state encoding seen on state_o, default
// cycle counts and a small max helper for timer sizing.
package lock_pkg;

    typedef enum logic [1:0] {
        LOCKED    = 2'd0,
        UNLOCKING = 2'd1,
        UNLOCKED  = 2'd2,
        LOCKING   = 2'd3
    } lock_state_t;

    // 500 ms settle and 5 s relock at 50 MHz.
    localparam int unsigned SETTLE_DEFAULT = 25_000_000;
    localparam int unsigned RELOCK_DEFAULT = 250_000_000;

    function automatic int unsigned max_u(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter shared by the settle and relock phases.
// Ports: clk, reset (sync, active-high), load/load_val, en, expired.
module cycle_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A load of N-1 gives exactly N cycles before expiry is acted on.
    assign expired = (count_q == '0);

endmodule

// File: rtl/lock_sequencer.sv
// Door lock sequencer: lock/unlock commands, settle window, auto-relock.
// Ports: clk, reset, unlock_req, lock_req, door_closed -> locked, busy,
// done, err (pulses) and state_o (display encoding).
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = SETTLE_DEFAULT,
    parameter int unsigned RELOCK_CYCLES = RELOCK_DEFAULT,
    parameter bit          AUTO_RELOCK   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       unlock_req,
    input  logic       lock_req,
    input  logic       door_closed,
    output logic       locked,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] state_o
);

    localparam int unsigned TMAX =
        max_u(SETTLE_CYCLES, RELOCK_CYCLES);
    localparam int unsigned TW = $clog2(TMAX + 1);

    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] RELOCK_LD = TW'(RELOCK_CYCLES - 1);

    lock_state_t   state_q;
    lock_state_t   state_d;
    logic          locked_q;
    logic          busy_q;
    logic          done_q;
    logic          done_d;
    logic          err_q;
    logic          err_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_en;
    logic          tmr_exp;

    logic          both;
    logic          any_req;
    logic          lock_only;
    logic          unlock_only;

    assign both        = lock_req & unlock_req;
    assign any_req     = lock_req | unlock_req;
    assign lock_only   = lock_req & ~unlock_req;
    assign unlock_only = unlock_req & ~lock_req;

    cycle_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expired  (tmr_exp)
    );

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = SETTLE_LD;
        tmr_en   = 1'b0;
        unique case (state_q)
            LOCKED: begin
                if (both) begin
                    err_d = 1'b1;
                end else if (unlock_req) begin
                    state_d  = UNLOCKING;
                    tmr_load = 1'b1;
                end
            end
            UNLOCKING: begin
                tmr_en = 1'b1;
                err_d  = any_req;
                if (tmr_exp) begin
                    state_d  = UNLOCKED;
                    done_d   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = RELOCK_LD;
                end
            end
            UNLOCKED: begin
                // Relock time only accrues with the door shut.
                tmr_en = AUTO_RELOCK && door_closed;
                err_d  = both;
                tmr_val = RELOCK_LD;
                if (lock_only && door_closed) begin
                    state_d  = LOCKING;
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LD;
                end else if (lock_only) begin
                    err_d    = 1'b1;
                    tmr_load = 1'b1;
                end else if (unlock_only) begin
                    tmr_load = 1'b1;
                end else if (!door_closed) begin
                    tmr_load = 1'b1;
                end else if (AUTO_RELOCK && tmr_exp) begin
                    state_d  = LOCKING;
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LD;
                end
            end
            LOCKING: begin
                tmr_en = 1'b1;
                err_d  = any_req;
                // Door opening mid-travel wins over settle expiry.
                if (!door_closed) begin
                    state_d  = UNLOCKING;
                    err_d    = 1'b1;
                    tmr_load = 1'b1;
                end else if (tmr_exp) begin
                    state_d = LOCKED;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            locked_q <= (state_d == LOCKED) ||
                        (state_d == LOCKING);
            busy_q   <= (state_d == UNLOCKING) ||
                        (state_d == LOCKING);
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign locked  = locked_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer with a cycle model.
// Directed scenarios plus a randomized run against the model.
module tb_lock_sequencer;

    localparam int SETTLE = 4;
    localparam int RELOCK = 10;
    localparam bit AUTO   = 1'b1;

    logic       clk;
    logic       reset;
    logic       unlock_req;
    logic       lock_req;
    logic       door_closed;
    logic       locked;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] state_o;

    int n_vec;
    int n_err;

    // Model: state name, cycles spent in a settle window, and
    // consecutive door-closed idle cycles in UNLOCKED.
    int m_state;
    int m_elapsed;
    int m_idle;
    bit m_done;
    bit m_err;

    lock_sequencer #(
        .SETTLE_CYCLES (SETTLE),
        .RELOCK_CYCLES (RELOCK),
        .AUTO_RELOCK   (AUTO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .unlock_req  (unlock_req),
        .lock_req    (lock_req),
        .door_closed (door_closed),
        .locked      (locked),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .state_o     (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] dut_v();
        return {locked, busy, done, err, state_o};
    endfunction

    function automatic logic [5:0] mdl_v();
        logic lk;
        logic bz;
        lk = (m_state == 0) || (m_state == 3);
        bz = (m_state == 1) || (m_state == 3);
        return {lk, bz, m_done, m_err, 2'(m_state)};
    endfunction

    task automatic model_step(input bit u, input bit l,
                              input bit d, input bit r);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (r) begin
            m_state   = 0;
            m_elapsed = 0;
            m_idle    = 0;
            return;
        end
        case (m_state)
            0: begin
                if (u && l) m_err = 1'b1;
                else if (u) begin
                    m_state   = 1;
                    m_elapsed = 0;
                end
            end
            1: begin
                if (u || l) m_err = 1'b1;
                m_elapsed++;
                if (m_elapsed == SETTLE) begin
                    m_state = 2;
                    m_done  = 1'b1;
                    m_idle  = 0;
                end
            end
            2: begin
                if (u && l) m_err = 1'b1;
                if (l && !u && d) begin
                    m_state   = 3;
                    m_elapsed = 0;
                end else if (l && !u) begin
                    m_err  = 1'b1;
                    m_idle = 0;
                end else if (u && !l) begin
                    m_idle = 0;
                end else if (!d) begin
                    m_idle = 0;
                end else begin
                    m_idle++;
                    if (AUTO && m_idle >= RELOCK) begin
                        m_state   = 3;
                        m_elapsed = 0;
                    end
                end
            end
            default: begin
                if (u || l) m_err = 1'b1;
                if (!d) begin
                    m_state   = 1;
                    m_elapsed = 0;
                    m_err     = 1'b1;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == SETTLE) begin
                        m_state = 0;
                        m_done  = 1'b1;
                    end
                end
            end
        endcase
    endtask

    task automatic tick(input bit u, input bit l,
                        input bit d, input bit r);
        unlock_req  = u;
        lock_req    = l;
        door_closed = d;
        reset       = r;
        @(posedge clk);
        model_step(u, l, d, r);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit d);
        for (int i = 0; i < n; i++) tick(0, 0, d, 0);
    endtask

    task automatic test_reset();
        tick(0, 0, 1, 1);
        tick(0, 0, 1, 1);
        n_vec++;
        if (dut_v() !== 6'b100000) begin
            n_err++;
            $display("FAIL reset: got %b want %b", dut_v(), 6'b100000);
        end
        for (int i = 0; i < 20; i++) begin
            tick(0, 0, 1, 0);
            n_vec++;
            if (dut_v() !== 6'b100000) begin
                n_err++;
                $display("FAIL reset_idle: got %b want %b",
                         dut_v(), 6'b100000);
            end
        end
    endtask

    task automatic test_unlock();
        tick(1, 0, 1, 0);
        for (int i = 1; i <= 4; i++) begin
            n_vec++;
            if (locked !== 1'b0 || busy !== 1'b1 ||
                state_o !== 2'd1) begin
                n_err++;
                $display("FAIL unlock_settle c%0d: got %b want lk0 bz1 st1",
                         i, dut_v());
            end
            tick(0, 0, 1, 0);
        end
        n_vec++;
        if (dut_v() !== 6'b001010) begin
            n_err++;
            $display("FAIL unlock_done: got %b want %b",
                     dut_v(), 6'b001010);
        end
    endtask

    task automatic test_auto_relock();
        for (int i = 1; i <= 9; i++) begin
            tick(0, 0, 1, 0);
            n_vec++;
            if (state_o !== 2'd2) begin
                n_err++;
                $display("FAIL relock_early c%0d: got %0d want 2",
                         i, state_o);
            end
        end
        tick(0, 0, 1, 0);
        n_vec++;
        if (dut_v() !== 6'b110011) begin
            n_err++;
            $display("FAIL relock_entry: got %b want %b",
                     dut_v(), 6'b110011);
        end
        idle(3, 1);
        tick(0, 0, 1, 0);
        n_vec++;
        if (dut_v() !== 6'b101000) begin
            n_err++;
            $display("FAIL relock_done: got %b want %b",
                     dut_v(), 6'b101000);
        end
    endtask

    task automatic test_door_open();
        tick(1, 0, 1, 0);
        idle(4, 1);
        for (int i = 1; i <= 30; i++) begin
            tick(0, (i == 10), 0, 0);
            n_vec++;
            if (state_o !== 2'd2 || err !== (i == 10)) begin
                n_err++;
                $display("FAIL door_open c%0d: got %b want st2 err%0d",
                         i, dut_v(), (i == 10));
            end
        end
        for (int i = 1; i <= 9; i++) begin
            tick(0, 0, 1, 0);
            n_vec++;
            if (state_o !== 2'd2) begin
                n_err++;
                $display("FAIL close_early c%0d: got %0d want 2",
                         i, state_o);
            end
        end
        tick(0, 0, 1, 0);
        n_vec++;
        if (state_o !== 2'd3) begin
            n_err++;
            $display("FAIL close_relock: got %0d want 3", state_o);
        end
        idle(4, 1);
    endtask

    task automatic test_abort();
        tick(1, 0, 1, 0);
        idle(4, 1);
        tick(0, 1, 1, 0);
        tick(0, 0, 1, 0);
        tick(0, 0, 0, 0);
        n_vec++;
        if (dut_v() !== 6'b010101) begin
            n_err++;
            $display("FAIL abort: got %b want %b",
                     dut_v(), 6'b010101);
        end
        idle(3, 0);
        n_vec++;
        if (state_o !== 2'd1) begin
            n_err++;
            $display("FAIL abort_hold: got %0d want 1", state_o);
        end
        tick(0, 0, 0, 0);
        n_vec++;
        if (dut_v() !== 6'b001010) begin
            n_err++;
            $display("FAIL abort_done: got %b want %b",
                     dut_v(), 6'b001010);
        end
        tick(0, 1, 1, 0);
        idle(4, 1);
    endtask

    task automatic test_both();
        tick(1, 1, 1, 0);
        n_vec++;
        if (dut_v() !== 6'b100100) begin
            n_err++;
            $display("FAIL both_locked: got %b want %b",
                     dut_v(), 6'b100100);
        end
        tick(0, 1, 1, 0);
        n_vec++;
        if (dut_v() !== 6'b100000) begin
            n_err++;
            $display("FAIL lock_when_locked: got %b want %b",
                     dut_v(), 6'b100000);
        end
    endtask

    task automatic test_expiry_collision();
        tick(1, 0, 1, 0);
        idle(3, 1);
        tick(0, 1, 1, 0);
        n_vec++;
        if (dut_v() !== 6'b001110) begin
            n_err++;
            $display("FAIL expiry_collision: got %b want %b",
                     dut_v(), 6'b001110);
        end
        tick(0, 1, 1, 0);
        idle(4, 1);
        n_vec++;
        if (state_o !== 2'd0) begin
            n_err++;
            $display("FAIL collision_relock: got %0d want 0", state_o);
        end
    endtask

    task automatic test_reset_mid();
        tick(1, 0, 0, 0);
        idle(2, 0);
        tick(0, 0, 0, 1);
        n_vec++;
        if (dut_v() !== 6'b100000) begin
            n_err++;
            $display("FAIL reset_mid: got %b want %b",
                     dut_v(), 6'b100000);
        end
        tick(0, 0, 1, 0);
    endtask

    task automatic test_random();
        bit d;
        d = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(14) == 0) d = ~d;
            tick(($urandom_range(7) == 0),
                 ($urandom_range(7) == 0),
                 d,
                 ($urandom_range(149) == 0));
            n_vec++;
            if (dut_v() !== mdl_v()) begin
                n_err++;
                $display("FAIL random c%0d: got %b want %b",
                         i, dut_v(), mdl_v());
            end
        end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        m_state     = 0;
        m_elapsed   = 0;
        m_idle      = 0;
        m_done      = 1'b0;
        m_err       = 1'b0;
        reset       = 1'b1;
        unlock_req  = 1'b0;
        lock_req    = 1'b0;
        door_closed = 1'b1;
        @(negedge clk);
        test_reset();
        test_unlock();
        test_auto_relock();
        test_door_open();
        test_abort();
        test_both();
        test_expiry_collision();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
